// File: rtl/lda_avalon_regs_pkg.sv
// lda_avalon_regs_pkg: register map, FSM/mode enums and point pack helpers for the LDA register file
package lda_avalon_regs_pkg;
  localparam logic [2:0] ADDR_MODE   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_GO     = 3'd2;
  localparam logic [2:0] ADDR_START  = 3'd3;
  localparam logic [2:0] ADDR_END    = 3'd4;
  localparam logic [2:0] ADDR_COLOR  = 3'd5;
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;
  typedef enum logic {STALL = 1'b0, POLL = 1'b1} mode_e;
  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [2:0] color;
  } line_t;
  function automatic logic [16:0] pt_pack(input logic [8:0] x, input logic [7:0] y);
    return {y, x};
  endfunction
  function automatic logic [8:0] pt_x(input logic [16:0] p);
    return p[8:0];
  endfunction
  function automatic logic [7:0] pt_y(input logic [16:0] p);
    return p[16:9];
  endfunction
endpackage

// File: rtl/lda_avalon_regs_if.sv
// lda_avalon_regs_if: Avalon-MM slave bus bundle between host and the LDA register file
interface lda_avalon_regs_if #(parameter int DATA_W = 32, parameter int ADDR_W = 3);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/lda_avalon_regs.sv
// lda_avalon_regs: Avalon-MM register file that snapshots line parameters and sequences the LDA start/done handshake
module lda_avalon_regs
  import lda_avalon_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  lda_avalon_regs_if.slave   avs,
  output logic [8:0]         o_x0,
  output logic [8:0]         o_x1,
  output logic [7:0]         o_y0,
  output logic [7:0]         o_y1,
  output logic [2:0]         o_color,
  output logic               o_start,
  input  logic               i_done
);
  state_e      state_q, state_d;
  mode_e       mode_q;
  logic [16:0] start_q, end_q;
  logic [2:0]  color_q;
  line_t       line_q;
  logic        start_q_pulse;
  logic [16:0] rdata;
  logic [2:0]  addr;
  logic        go, accept, unused_ok;
  assign addr      = 3'(avs.address);
  assign go        = avs.write && addr == ADDR_GO;
  assign accept    = go && state_q == IDLE;
  assign unused_ok = ^{avs.read, avs.writedata[DATA_W-1:17]};
  assign o_x0      = line_q.x0;
  assign o_y0      = line_q.y0;
  assign o_x1      = line_q.x1;
  assign o_y1      = line_q.y1;
  assign o_color   = line_q.color;
  assign o_start   = start_q_pulse;
  always_comb begin
    case (addr)
      ADDR_MODE:   rdata = 17'(mode_q);
      ADDR_STATUS: rdata = 17'(state_q != IDLE);
      ADDR_START:  rdata = start_q;
      ADDR_END:    rdata = end_q;
      ADDR_COLOR:  rdata = 17'(color_q);
      default:     rdata = '0;
    endcase
    avs.readdata = DATA_W'(rdata);
    // in stall mode the GO write is held until DONE; in poll mode only a line in flight stalls it
    avs.waitrequest = i_reset_n && go &&
                      (state_q == START || state_q == BUSY || (state_q == IDLE && mode_q == STALL));
    state_d = state_q == IDLE  ? (accept ? START : IDLE) :
              state_q == START ? BUSY :
              state_q == BUSY  ? (i_done ? (mode_q == POLL ? IDLE : DONE) : BUSY) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      mode_q        <= STALL;
      start_q       <= '0;
      end_q         <= '0;
      color_q       <= '0;
      line_q        <= '0;
      start_q_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q_pulse <= accept;
      if (accept) line_q <= '{x0: pt_x(start_q), y0: pt_y(start_q),
                              x1: pt_x(end_q), y1: pt_y(end_q), color: color_q};
      if (avs.write && addr == ADDR_MODE)  mode_q  <= mode_e'(avs.writedata[0]);
      if (avs.write && addr == ADDR_START) start_q <= avs.writedata[16:0];
      if (avs.write && addr == ADDR_END)   end_q   <= avs.writedata[16:0];
      if (avs.write && addr == ADDR_COLOR) color_q <= avs.writedata[2:0];
    end
  end
endmodule

// File: tb/tb_lda_avalon_regs.sv
// tb_lda_avalon_regs: randomized self-checking bench for the LDA Avalon register file
module tb_lda_avalon_regs;
  logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [8:0] ox0, ox1;
  logic [7:0] oy0, oy1;
  logic [2:0] ocolor;
  logic start;
  int checks = 0, errors = 0, starts = 0;
  logic [31:0] stg [8];
  logic [36:0] snap;
  lda_avalon_regs_if #(.DATA_W(32), .ADDR_W(3)) avs ();
  lda_avalon_regs #(.DATA_W(32), .ADDR_W(3)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .avs(avs),
    .o_x0(ox0), .o_x1(ox1), .o_y0(oy0), .o_y1(oy1), .o_color(ocolor),
    .o_start(start), .i_done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (start === 1'b1) starts++;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] mask_of(input int a);
    return a == 0 ? 32'h1 : (a == 3 || a == 4) ? 32'h1FFFF : a == 5 ? 32'h7 : 32'h0;
  endfunction
  function automatic logic [36:0] line_of();
    logic [31:0] s = stg[3], e = stg[4];
    return {9'(s % 512), 8'(s / 512), 9'(e % 512), 8'(e / 512), 3'(stg[5])};
  endfunction
  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    avs.address = 3'(a); avs.writedata = d; avs.write = 1'b1;
    #1;
    checks++;
    if (avs.waitrequest !== 1'b0) begin
      errors++; $display("FAIL write_nostall a=%0d got %b exp 0", a, avs.waitrequest);
    end
    @(negedge clk);
    avs.write = 1'b0;
    stg[a] = d & mask_of(a);
  endtask
  task automatic bus_read(input int a, output logic [31:0] v);
    @(negedge clk);
    avs.address = 3'(a); avs.read = 1'b1;
    #1 v = avs.readdata;
    avs.read = 1'b0;
  endtask
  task automatic stage_random();
    bus_write(3, $urandom);
    bus_write(4, $urandom);
    bus_write(5, $urandom);
  endtask
  task automatic test_reset();
    logic [31:0] v;
    avs.address = '0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = '0;
    for (int a = 0; a < 8; a++) stg[a] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({avs.waitrequest, start, ox0, oy0, ox1, oy1, ocolor} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {avs.waitrequest, start, ox0, oy0, ox1, oy1, ocolor});
    end
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(a, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_read a=%0d got %h exp 0", a, v); end
    end
  endtask
  task automatic test_stall(input int x0, input int y0, input int x1, input int y1, input int c, input int lat);
    int s0;
    logic [31:0] v;
    bus_write(0, 0);
    bus_write(3, y0 * 512 + x0);
    bus_write(4, y1 * 512 + x1);
    bus_write(5, c);
    s0 = starts;
    @(negedge clk);
    avs.address = 3'd2; avs.writedata = $urandom; avs.write = 1'b1;
    #1 snap = line_of();
    checks++;
    if (avs.waitrequest !== 1'b1) begin errors++; $display("FAIL stall_go_wr got %b exp 1", avs.waitrequest); end
    @(negedge clk); #1;
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL stall_start got %b exp 1", start); end
    checks++;
    if ({ox0, oy0, ox1, oy1, ocolor} !== snap) begin
      errors++; $display("FAIL stall_snapshot got %h exp %h", {ox0, oy0, ox1, oy1, ocolor}, snap);
    end
    repeat (lat) begin
      @(negedge clk); #1;
      checks++;
      if ({avs.waitrequest, start} !== 2'b10) begin
        errors++; $display("FAIL stall_busy wr/start got %b exp 10", {avs.waitrequest, start});
      end
    end
    @(negedge clk);
    done = 1'b1;
    #1;
    checks++;
    if (avs.waitrequest !== 1'b1) begin errors++; $display("FAIL stall_done_wr got %b exp 1", avs.waitrequest); end
    @(negedge clk);
    done = 1'b0;
    #1;
    checks++;
    if (avs.waitrequest !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", avs.waitrequest); end
    @(negedge clk);
    avs.write = 1'b0;
    #1;
    checks++;
    if (starts - s0 !== 1) begin errors++; $display("FAIL stall_one_start got %0d exp 1", starts - s0); end
    bus_read(1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL stall_status_idle got %h exp 0", v); end
  endtask
  task automatic test_poll();
    int s0;
    logic [31:0] v;
    bus_write(0, 1);
    stage_random();
    s0 = starts;
    @(negedge clk);
    avs.address = 3'd2; avs.write = 1'b1;
    #1 snap = line_of();
    checks++;
    if (avs.waitrequest !== 1'b0) begin errors++; $display("FAIL poll_go_wr got %b exp 0", avs.waitrequest); end
    @(negedge clk);
    avs.write = 1'b0;
    bus_read(1, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL poll_status_busy got %h exp 1", v); end
    bus_write(3, 0);
    #1;
    checks++;
    if ({ox0, oy0, ox1, oy1, ocolor} !== snap) begin
      errors++; $display("FAIL poll_stable got %h exp %h", {ox0, oy0, ox1, oy1, ocolor}, snap);
    end
    @(negedge clk) done = 1'b1;
    @(negedge clk) done = 1'b0;
    bus_read(1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL poll_status_idle got %h exp 0", v); end
    checks++;
    if (starts - s0 !== 1) begin errors++; $display("FAIL poll_one_start got %0d exp 1", starts - s0); end
  endtask
  task automatic test_back_to_back();
    int s0;
    logic [31:0] v;
    stage_random();
    s0 = starts;
    @(negedge clk);
    avs.address = 3'd2; avs.write = 1'b1;
    #1 snap = line_of();
    checks++;
    if (avs.waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_first_wr got %b exp 0", avs.waitrequest); end
    @(negedge clk);
    avs.write = 1'b0;
    bus_write(3, $urandom);
    @(negedge clk);
    avs.address = 3'd2; avs.write = 1'b1;
    repeat (4) begin
      #1;
      checks++;
      if ({avs.waitrequest, ox0, oy0, ox1, oy1, ocolor} !== {1'b1, snap}) begin
        errors++; $display("FAIL b2b_hold got %h exp %h", {avs.waitrequest, ox0, oy0, ox1, oy1, ocolor}, {1'b1, snap});
      end
      @(negedge clk);
    end
    done = 1'b1;
    #1;
    checks++;
    if (avs.waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_done_wr got %b exp 1", avs.waitrequest); end
    @(negedge clk);
    done = 1'b0;
    #1 snap = line_of();
    checks++;
    if (avs.waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_regrant got %b exp 0", avs.waitrequest); end
    @(negedge clk);
    avs.write = 1'b0;
    #1;
    checks++;
    if ({start, ox0, oy0, ox1, oy1, ocolor} !== {1'b1, snap}) begin
      errors++; $display("FAIL b2b_second_line got %h exp %h", {start, ox0, oy0, ox1, oy1, ocolor}, {1'b1, snap});
    end
    @(negedge clk) done = 1'b1;
    @(negedge clk) done = 1'b0;
    #1;
    checks++;
    if (starts - s0 !== 2) begin errors++; $display("FAIL b2b_two_starts got %0d exp 2", starts - s0); end
    bus_read(1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL b2b_status_idle got %h exp 0", v); end
  endtask
  task automatic test_reset_mid();
    int s0;
    logic [31:0] v;
    bus_write(0, 0);
    stage_random();
    @(negedge clk);
    avs.address = 3'd2; avs.write = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (avs.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_pre_wr got %b exp 1", avs.waitrequest); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({avs.waitrequest, start, ox0, oy0, ox1, oy1, ocolor} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got %h exp 0", {avs.waitrequest, start, ox0, oy0, ox1, oy1, ocolor});
    end
    @(negedge clk);
    avs.write = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) stg[a] = '0;
    s0 = starts;
    @(negedge clk) done = 1'b1;
    @(negedge clk) done = 1'b0;
    bus_read(1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", v); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({starts - s0, ox0, oy0, ox1, oy1, ocolor} !== '0) begin
      errors++; $display("FAIL rst_late_done got starts=%0d line=%h exp 0", starts - s0, {ox0, oy0, ox1, oy1, ocolor});
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(a, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL rst_regs a=%0d got %h exp 0", a, v); end
    end
  endtask
  task automatic test_regs();
    logic [31:0] v;
    int a;
    bus_write(3, 32'h1FFFF);
    bus_read(3, v);
    checks++;
    if (v !== 32'h1FFFF) begin errors++; $display("FAIL regs_start_full got %h exp 1ffff", v); end
    bus_read(6, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL regs_addr6 got %h exp 0", v); end
    bus_write(5, 32'hFFFFFFFF);
    bus_read(5, v);
    checks++;
    if (v !== 32'h7) begin errors++; $display("FAIL regs_color_mask got %h exp 7", v); end
    repeat (24) begin
      a = $urandom_range(0, 7);
      if (a != 2) bus_write(a, $urandom);
      a = $urandom_range(0, 7);
      bus_read(a, v);
      checks++;
      if (v !== (a == 2 ? 32'h0 : stg[a])) begin
        errors++; $display("FAIL regs_random a=%0d got %h exp %h", a, v, (a == 2 ? 32'h0 : stg[a]));
      end
    end
  endtask
  initial begin
    test_reset();
    test_stall(10, 20, 300, 200, 5, 5);
    test_stall($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 255),
               $urandom_range(0, 7), $urandom_range(1, 9));
    test_poll();
    test_back_to_back();
    test_reset_mid();
    test_regs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
